// File: rtl/loongarch_pkg.sv
// Shared LoongArch pipeline types: load-type encodings, widths and the MEM->WB payload.
// WB_DEBUG_TRACE_EN adds the retired PC to the latched payload.
package loongarch_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned GR_W      = 5;
    localparam int unsigned LD_TYPE_W = 3;

    localparam logic [LD_TYPE_W-1:0] LD_W  = 3'd0;
    localparam logic [LD_TYPE_W-1:0] LD_B  = 3'd1;
    localparam logic [LD_TYPE_W-1:0] LD_H  = 3'd2;
    localparam logic [LD_TYPE_W-1:0] LD_BU = 3'd3;
    localparam logic [LD_TYPE_W-1:0] LD_HU = 3'd4;

    typedef struct packed {
`ifdef WB_DEBUG_TRACE_EN
        logic [DATA_W-1:0]    pc;
`endif
        logic                 gr_we;
        logic [GR_W-1:0]      dest;
        logic                 res_from_mem;
        logic [LD_TYPE_W-1:0] ld_type;
        logic [DATA_W-1:0]    result;
    } ms_to_ws_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks byte/halfword from the aligned bus word and extends it.
module load_align
    import loongarch_pkg::*;
(
    input  logic [LD_TYPE_W-1:0] ld_type,
    input  logic [1:0]           off,
    input  logic [DATA_W-1:0]    rdata,
    output logic [DATA_W-1:0]    value_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // off[0] is deliberately ignored: misaligned halfwords trap before WB
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        value_c = rdata;
        case (ld_type)
            LD_B:    value_c = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   value_c = {24'd0, byte_sel};
            LD_H:    value_c = {{16{half_sel[15]}}, half_sel};
            LD_HU:   value_c = {16'd0, half_sel};
            default: value_c = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction from MEM, waits for load data, drives GR write and forwarding.
// WB_DEBUG_TRACE_EN adds the debug_wb_* retirement trace ports.
module wb_stage
    import loongarch_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [31:0]       ms_pc,
    input  logic              ms_gr_we,
    input  logic [ADDR_W-1:0] ms_dest,
    input  logic              ms_res_from_mem,
    input  logic [2:0]        ms_ld_type,
    input  logic [DATA_W-1:0] ms_result,

    input  logic              data_rvalid,
    input  logic [DATA_W-1:0] data_rdata,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,

    output logic              ws_fwd_valid,
    output logic [ADDR_W-1:0] ws_fwd_dest,
    output logic [DATA_W-1:0] ws_fwd_data,
    output logic              ws_fwd_block
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
`endif
);

    logic              ws_valid_q, ws_valid_d;
    ms_to_ws_t         ws_q, ws_d;
    logic              ws_ready_go;
    logic              retire_c;
    logic              dest_nz;
    logic [DATA_W-1:0] load_data_c;

    assign ws_ready_go = !ws_q.res_from_mem || data_rvalid;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;
    assign retire_c    = ws_valid_q && ws_ready_go;
    assign dest_nz     = (ws_q.dest != '0);

    // Accept/retire bookkeeping; accept and retire may coincide on one edge
    always_comb begin
        ws_valid_d = ws_valid_q;
        ws_d       = ws_q;
        if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
            if (ms_to_ws_valid) begin
`ifdef WB_DEBUG_TRACE_EN
                ws_d.pc       = ms_pc;
`endif
                ws_d.gr_we        = ms_gr_we;
                ws_d.dest         = GR_W'(ms_dest);
                ws_d.res_from_mem = ms_res_from_mem;
                ws_d.ld_type      = LD_TYPE_W'(ms_ld_type);
                ws_d.result       = ms_result;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws_valid_q <= 1'b0;
            ws_q       <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            ws_q       <= ws_d;
        end
    end

    load_align u_load_align (
        .ld_type (ws_q.ld_type),
        .off     (ws_q.result[1:0]),
        .rdata   (data_rdata),
        .value_c (load_data_c)
    );

    always_comb begin
        rf_we        = retire_c && ws_q.gr_we && dest_nz;
        rf_waddr     = ADDR_W'(ws_q.dest);
        rf_wdata     = ws_q.res_from_mem ? load_data_c : ws_q.result;
        ws_fwd_valid = rf_we;
        ws_fwd_dest  = ADDR_W'(ws_q.dest);
        ws_fwd_data  = rf_wdata;
        // a load still waiting on the bus must stall any dependent reader in ID
        ws_fwd_block = ws_valid_q && ws_q.res_from_mem && !data_rvalid
                       && ws_q.gr_we && dest_nz;
    end

`ifdef WB_DEBUG_TRACE_EN
    always_comb begin
        debug_wb_pc       = retire_c ? ws_q.pc : 32'd0;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = retire_c ? 5'(ws_q.dest) : 5'd0;
        debug_wb_rf_wdata = retire_c ? 32'(rf_wdata) : 32'd0;
    end
`else
    logic unused_pc;
    assign unused_pc = ^ms_pc;
`endif

endmodule
